// File: rtl/m10k_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : m10k_arbiter_if
//  Purpose  : Bundles the two requester handshakes and the M10K memory
//             command/data lines that connect to the round-robin arbiter.
//             "master" is the environment side (requesters + memory),
//             "slave" is the arbiter side.
//  Revision : 1.0  initial release
// ============================================================================
interface m10k_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
);
    // Requester 0
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    // Requester 1
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    // Memory side
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write;
    logic [DATA_W-1:0] mem_data_out;

    modport master (
        output req0, we0, addr0, wdata0,
        input  gnt0, rvalid0, rdata0,
        output req1, we1, addr1, wdata1,
        input  gnt1, rvalid1, rdata1,
        input  mem_address, mem_data_in, mem_write,
        output mem_data_out
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        output gnt0, rvalid0, rdata0,
        input  req1, we1, addr1, wdata1,
        output gnt1, rvalid1, rdata1,
        output mem_address, mem_data_in, mem_write,
        input  mem_data_out
    );
endinterface
`default_nettype wire

// File: rtl/m10k_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : m10k_arbiter
//  Purpose  : Two-requester round-robin arbiter/sequencer for a 32x4 M10K
//             block with registered inputs. Each transaction takes three
//             cycles: IDLE (arbitrate) -> ISSUE (memory samples command)
//             -> WAIT (read data valid, captured on the way back to IDLE).
//             Every output is driven from a register.
//  Revision : 1.0  initial release
// ============================================================================
module m10k_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    m10k_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Round-robin history and the latched command of the current winner
    logic last_grant, last_grant_nxt;
    logic op_we,      op_we_nxt;
    logic op_owner,   op_owner_nxt;

    // Output registers and their next values
    logic              gnt0_q,    gnt0_nxt;
    logic              gnt1_q,    gnt1_nxt;
    logic              rvalid0_q, rvalid0_nxt;
    logic              rvalid1_q, rvalid1_nxt;
    logic [DATA_W-1:0] rdata0_q,  rdata0_nxt;
    logic [DATA_W-1:0] rdata1_q,  rdata1_nxt;
    logic [ADDR_W-1:0] mem_address_q, mem_address_nxt;
    logic [DATA_W-1:0] mem_data_in_q, mem_data_in_nxt;
    logic              mem_write_q,   mem_write_nxt;

    // Requester 1 wins when it is alone, or on a tie when 0 was served last
    logic pick1;
    assign pick1 = bus.req1 & (~bus.req0 | ~last_grant);

    // Next-state and next-output decode; everything defaults to "hold" or 0
    always_comb begin
        state_nxt       = state;
        last_grant_nxt  = last_grant;
        op_we_nxt       = op_we;
        op_owner_nxt    = op_owner;
        gnt0_nxt        = 1'b0;
        gnt1_nxt        = 1'b0;
        rvalid0_nxt     = 1'b0;
        rvalid1_nxt     = 1'b0;
        rdata0_nxt      = rdata0_q;
        rdata1_nxt      = rdata1_q;
        mem_address_nxt = mem_address_q;
        mem_data_in_nxt = mem_data_in_q;
        mem_write_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.req0 | bus.req1) begin
                    op_owner_nxt    = pick1;
                    op_we_nxt       = pick1 ? bus.we1    : bus.we0;
                    mem_address_nxt = pick1 ? bus.addr1  : bus.addr0;
                    mem_data_in_nxt = pick1 ? bus.wdata1 : bus.wdata0;
                    mem_write_nxt   = pick1 ? bus.we1    : bus.we0;
                    gnt0_nxt        = ~pick1;
                    gnt1_nxt        = pick1;
                    last_grant_nxt  = pick1;
                    state_nxt       = ISSUE;
                end
            end
            ISSUE: begin
                // Memory captures the command at the end of this cycle;
                // address and data stay put, write strobe drops.
                state_nxt = WAIT;
            end
            WAIT: begin
                if (!op_we) begin
                    if (op_owner) begin
                        rdata1_nxt  = bus.mem_data_out;
                        rvalid1_nxt = 1'b1;
                    end else begin
                        rdata0_nxt  = bus.mem_data_out;
                        rvalid0_nxt = 1'b1;
                    end
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, arbitration history and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            op_we         <= 1'b0;
            op_owner      <= 1'b0;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            mem_write_q   <= 1'b0;
        end else begin
            state         <= state_nxt;
            last_grant    <= last_grant_nxt;
            op_we         <= op_we_nxt;
            op_owner      <= op_owner_nxt;
            gnt0_q        <= gnt0_nxt;
            gnt1_q        <= gnt1_nxt;
            rvalid0_q     <= rvalid0_nxt;
            rvalid1_q     <= rvalid1_nxt;
            rdata0_q      <= rdata0_nxt;
            rdata1_q      <= rdata1_nxt;
            mem_address_q <= mem_address_nxt;
            mem_data_in_q <= mem_data_in_nxt;
            mem_write_q   <= mem_write_nxt;
        end
    end

    assign bus.gnt0        = gnt0_q;
    assign bus.gnt1        = gnt1_q;
    assign bus.rvalid0     = rvalid0_q;
    assign bus.rvalid1     = rvalid1_q;
    assign bus.rdata0      = rdata0_q;
    assign bus.rdata1      = rdata1_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data_in = mem_data_in_q;
    assign bus.mem_write   = mem_write_q;

endmodule
`default_nettype wire

// File: doc/m10k_arbiter.md
Name: m10k_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the registered-input 32x4 single-port M10K memory block.
- Serialises read and write transactions from two masters onto the memory's address, data_in and write inputs.
- Accounts for the memory's one-cycle input-register latency and captures read data for the winning master.
- Sits between the lab datapath masters and the memory instance.

Parameters:
- ADDR_W, 5, memory address width (depth 2**ADDR_W = 32).
- DATA_W, 4, memory data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 transaction request; held high until gnt0 is seen.
- we0  input  1  requester 0: 1 = write, 0 = read; stable while req0 is high.
- addr0  input  ADDR_W  requester 0 address.
- wdata0  input  DATA_W  requester 0 write data.
- gnt0  output  1  one-cycle grant pulse to requester 0.
- rvalid0  output  1  one-cycle pulse: rdata0 holds read result.
- rdata0  output  DATA_W  requester 0 read data; holds its value until the next read completes.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  as above, for requester 1.
- mem_address  output  ADDR_W  to the memory's address input.
- mem_data_in  output  DATA_W  to the memory's data_in input.
- mem_write  output  1  to the memory's write input.
- mem_data_out  input  DATA_W  from the memory's data_out output.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; last_grant=1, so requester 0 wins the first tie; all outputs are 0.
- All outputs are registered.
- States:
  - IDLE: arbitration happens only here.
  - ISSUE: the memory samples the command.
  - WAIT: memory read data is valid.
- IDLE transitions:
  - No request: stay in IDLE.
  - Only one req high: that requester wins.
  - Both high: the requester not equal to last_grant wins.
- On winning (edge E0):
  - Latch we, addr and wdata.
  - Drive mem_address=addr, mem_data_in=wdata, mem_write=we.
  - Assert gnt of the winner for one cycle.
  - Update last_grant; go to ISSUE.
- ISSUE (edge E1):
  - The memory registers the command on this edge.
  - Controller drives mem_write=0 and holds mem_address and mem_data_in.
  - Clear gnt; go to WAIT.
- WAIT (edge E2):
  - If the latched op is a read: capture mem_data_out into the winner's rdata and pulse its rvalid for one cycle.
  - A write produces no rvalid.
  - Go to IDLE.
- Timing:
  - mem_write is high for exactly one cycle per write; it is never high outside ISSUE.
  - mem_address is held unchanged from E0 until the next grant.
  - Transaction occupancy is 3 cycles: grant to rvalid = 2 cycles; req sampled to rvalid = 3 edges.
  - Maximum throughput is one transaction per 3 cycles.
  - Under continuous contention the grants alternate 0,1,0,1 (no starvation).
- Requester protocol:
  - A requester seeing gnt may drop req or change its command from the next cycle.
  - req held high after gnt is treated as a new request at the next IDLE.
  - A req deasserted before grant is simply not served; no error.
- Reset mid-operation:
  - Return to IDLE; gnt, rvalid and mem_write are forced to 0; rdata is cleared.
  - A write whose E0 edge precedes the reset edge still commits in memory, because the memory samples mem_write=1 at that reset edge.
  - No rvalid is produced for an aborted read.
- Wrap-around: addresses 0 to 31 only; no address arithmetic; addr=31 is valid.

Test Plan:
- Reset, then req0=1, we0=1, addr0=5, wdata0=0xA for one grant, then req0 read addr0=5 -> gnt0 pulses; mem_write high for exactly 1 cycle; rvalid0 pulses 2 cycles after the second gnt0 with rdata0=0xA.
- req0 and req1 both continuous reads (addr0=3, addr1=4, memory preloaded 0x3/0x4) -> grant order 0,1,0,1 with a gnt every 3 cycles; rdata0=0x3, rdata1=0x4; rvalid0 and rvalid1 never both high.
- req1 only, write addr=31 data=0xF, then read addr=31 -> rdata1=0xF; rvalid0 and gnt0 stay 0.
- Back-to-back writes: addr=0 data=0x1 then addr=0 data=0x2, then read addr=0 -> rdata=0x2; mem_write is low in every IDLE and WAIT cycle.
- rst asserted in the WAIT cycle of a read -> no rvalid; all outputs 0 the next cycle; the next request is granted normally with last_grant=1 semantics (req0 wins a tie).
- rst asserted in the ISSUE cycle of a write of 0x6 to addr 7 -> mem_write=0 after the reset edge; a subsequent read of addr 7 returns 0x6.
